// File: rtl/fpnew_lane_iter_div.sv
// Iterative unsigned restoring divider lane for the shared aux FSM chain.
// A single start pulse launches an op, and fsm_ready_o reports "lane done".
// A divide-by-zero answers in the start cycle (early out).
//
// state | meaning
// IDLE  | no result pending, lane ready
// BUSY  | shift-subtract iterations running
// DONE  | result valid and held until the next active start
module fpnew_lane_iter_div #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             lane_active_i,
  input  logic             fsm_start_i,
  input  logic             flush_i,
  output logic             fsm_ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             busy_o
);

  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   q_q, r_q;
  logic               dz_q;
  logic               load, early;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, handshake and result outputs (early out bypasses the registers).
  always_comb begin
    state_d     = state_q;
    fsm_ready_o = 1'b1;
    busy_o      = 1'b0;
    load        = 1'b0;
    early       = 1'b0;
    quotient_o  = q_q;
    remainder_o = r_q;
    div_zero_o  = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (fsm_start_i && !flush_i) begin
          if (!lane_active_i) begin
            state_d = IDLE;
          end else if (divisor_i == '0) begin
            early       = 1'b1;
            state_d     = DONE;
            quotient_o  = '1;
            remainder_o = dividend_i;
            div_zero_o  = 1'b1;
          end else begin
            load        = 1'b1;
            state_d     = BUSY;
            fsm_ready_o = 1'b0;
          end
        end
      end
      BUSY: begin
        fsm_ready_o = 1'b0;
        busy_o      = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // BITS_PER_CYCLE restoring steps; quotient bits shift in where dividend bits leave.
  always_comb begin
    rem_nxt = rem_q;
    quo_nxt = quo_q;
    shifted = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_nxt, quo_nxt[WIDTH-1]};
      if (shifted >= {1'b0, dvsr_q}) begin
        rem_nxt = WIDTH'(shifted - {1'b0, dvsr_q});
        quo_nxt = {quo_nxt[WIDTH-2:0], 1'b1};
      end else begin
        rem_nxt = shifted[WIDTH-1:0];
        quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Working registers and held results; results only change on the last step,
  // the early out, flush or reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else if (flush_i) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else if (early) begin
      q_q  <= '1;
      r_q  <= dividend_i;
      dz_q <= 1'b1;
    end else if (load) begin
      cnt_q  <= CNT_W'(ITER);
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvsr_q <= divisor_i;
      dz_q   <= 1'b0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (cnt_q == CNT_W'(1)) begin
        q_q <= quo_nxt;
        r_q <= rem_nxt;
      end
    end
  end

  // A start while iterating breaks the lock-step contract with the aux FSM.
  a_no_start_in_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(state_q == BUSY && fsm_start_i && !flush_i));

endmodule

// File: tb/tb_fpnew_lane_iter_div.sv
// Directed and random checks of the divider lane at BITS_PER_CYCLE 1 and 4.
module tb_fpnew_lane_iter_div;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] a_dvd, a_dvs, a_q, a_r;
  logic       a_act, a_start, a_flush, a_rdy, a_dz, a_busy;
  logic [7:0] b_dvd, b_dvs, b_q, b_r;
  logic       b_act, b_start, b_flush, b_rdy, b_dz, b_busy;

  fpnew_lane_iter_div #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .dividend_i(a_dvd), .divisor_i(a_dvs),
    .lane_active_i(a_act), .fsm_start_i(a_start), .flush_i(a_flush),
    .fsm_ready_o(a_rdy), .quotient_o(a_q), .remainder_o(a_r),
    .div_zero_o(a_dz), .busy_o(a_busy));

  fpnew_lane_iter_div #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .dividend_i(b_dvd), .divisor_i(b_dvs),
    .lane_active_i(b_act), .fsm_start_i(b_start), .flush_i(b_flush),
    .fsm_ready_o(b_rdy), .quotient_o(b_q), .remainder_o(b_r),
    .div_zero_o(b_dz), .busy_o(b_busy));

  logic       sel;
  logic [7:0] q, r;
  logic       rdy, dz, busy;
  assign q    = sel ? b_q    : a_q;
  assign r    = sel ? b_r    : a_r;
  assign rdy  = sel ? b_rdy  : a_rdy;
  assign dz   = sel ? b_dz   : a_dz;
  assign busy = sel ? b_busy : a_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_q, prev_r;
  logic       prev_dz;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic       act;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edz;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] req);
    checks++;
    if (actual !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, actual, req, $time);
    end
  endtask

  task automatic drive(input logic [7:0] dvd, input logic [7:0] dvs, input logic act,
                       input logic start, input logic flush);
    if (sel) begin
      b_dvd = dvd; b_dvs = dvs; b_act = act; b_start = start; b_flush = flush;
    end else begin
      a_dvd = dvd; a_dvs = dvs; a_act = act; a_start = start; a_flush = flush;
    end
  endtask

  task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs, input logic act,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int lat);
    int n;
    @(negedge clk);
    drive(dvd, dvs, act, 1'b1, 1'b0);
    #1;
    chk("ready_c0", rdy, (lat == 0));
    if (act && dvs == 8'd0) begin
      chk("early_q", q, eq);
      chk("early_r", r, er);
      chk("early_dz", dz, 1'b1);
    end else begin
      chk("hold_q_c0", q, prev_q);
      chk("hold_r_c0", r, prev_r);
    end
    if (lat > 0) begin
      n = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        drive(dvd, dvs, 1'b0, 1'b0, 1'b0);
        #1;
        if (k == 1) chk("busy_c1", busy, 1'b1);
        if (rdy) begin
          n = k;
          break;
        end
      end
      chk("latency", n, lat);
    end else begin
      @(negedge clk);
      drive(dvd, dvs, 1'b0, 1'b0, 1'b0);
      #1;
      chk("ready_c1", rdy, 1'b1);
    end
    chk("quotient", q, eq);
    chk("remainder", r, er);
    chk("div_zero", dz, edz);
    prev_q = eq; prev_r = er; prev_dz = edz;
  endtask

  initial begin
    logic [7:0] x, y;
    tbl[0] = '{8'd100, 8'd7,   1'b1, 8'd14,  8'd2,  1'b0, 9};
    tbl[1] = '{8'd5,   8'd0,   1'b1, 8'hFF,  8'd5,  1'b1, 0};
    tbl[2] = '{8'd33,  8'd4,   1'b0, 8'hFF,  8'd5,  1'b1, 0};
    tbl[3] = '{8'd200, 8'd3,   1'b1, 8'd66,  8'd2,  1'b0, 9};
    tbl[4] = '{8'd255, 8'd16,  1'b1, 8'd15,  8'd15, 1'b0, 9};
    tbl[5] = '{8'd0,   8'd9,   1'b1, 8'd0,   8'd0,  1'b0, 9};
    tbl[6] = '{8'd7,   8'd200, 1'b1, 8'd0,   8'd7,  1'b0, 9};
    tbl[7] = '{8'd255, 8'd1,   1'b1, 8'd255, 8'd0,  1'b0, 9};
    tbl[8] = '{8'd0,   8'd0,   1'b1, 8'hFF,  8'd0,  1'b1, 0};
    tbl[9] = '{8'd128, 8'd128, 1'b1, 8'd1,   8'd0,  1'b0, 9};

    rst_n = 1'b0;
    sel = 1'b1; drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    sel = 1'b0; drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", a_rdy, 1'b1);
    chk("rst_q", a_q, 8'd0);
    chk("rst_r", a_r, 8'd0);
    chk("rst_dz", a_dz, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_q = 8'd0; prev_r = 8'd0; prev_dz = 1'b0;

    // Table vectors on the one-bit-per-cycle lane, back to back.
    for (int i = 0; i < 10; i++)
      run_op(tbl[i].dvd, tbl[i].dvs, tbl[i].act, tbl[i].eq, tbl[i].er, tbl[i].edz, tbl[i].lat);

    // Inactive start keeps ready high across several cycles.
    @(negedge clk);
    drive(8'd9, 8'd2, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("inactive_ready", rdy, 1'b1);
      @(negedge clk);
      drive(8'd9, 8'd2, 1'b0, 1'b0, 1'b0);
    end
    #1;
    chk("inactive_q", q, prev_q);
    chk("inactive_r", r, prev_r);

    // Flush four cycles into 255/1.
    @(negedge clk);
    drive(8'd255, 8'd1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(8'd255, 8'd1, 1'b0, 1'b0, (k == 4));
      #1;
      if (k == 1) chk("flush_busy_c1", busy, 1'b1);
    end
    chk("flush_ready_c4", rdy, 1'b0);
    @(negedge clk);
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_ready", rdy, 1'b1);
    chk("flush_q", q, 8'd0);
    chk("flush_r", r, 8'd0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_dz", dz, 1'b0);
    prev_q = 8'd0; prev_r = 8'd0; prev_dz = 1'b0;

    run_op(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0, 9);

    // Asynchronous reset in the middle of an op.
    @(negedge clk);
    drive(8'd250, 8'd3, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(8'd250, 8'd3, 1'b0, 1'b0, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", rdy, 1'b1);
    chk("arst_q", q, 8'd0);
    chk("arst_r", r, 8'd0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_q = 8'd0; prev_r = 8'd0; prev_dz = 1'b0;
    run_op(8'd250, 8'd3, 1'b1, 8'd83, 8'd1, 1'b0, 9);

    // Four-bits-per-cycle lane: directed then random against / and %.
    sel = 1'b1;
    prev_q = 8'd0; prev_r = 8'd0; prev_dz = 1'b0;
    run_op(8'd255, 8'd16, 1'b1, 8'd15, 8'd15, 1'b0, 3);
    run_op(8'd5, 8'd0, 1'b1, 8'hFF, 8'd5, 1'b1, 0);
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 255));
      y = (i % 50 == 7) ? 8'd0 : 8'($urandom_range(0, 255));
      if (y == 8'd0) run_op(x, y, 1'b1, 8'hFF, x, 1'b1, 0);
      else           run_op(x, y, 1'b1, x / y, x % y, 1'b0, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
